rs_rr_arbiter: RTL and testbench

- N-source round-robin arbiter that shares one downstream valid/ready register-slice channel between several upstream requesters.
- Each source presents beats with a last flag. Once a source wins, it keeps the channel until its last beat is accepted (packet lock).
- The output is fully registered: one-cycle latency, full throughput. It sits between the requester ports and the shared FIFO/register-slice datapath.

---
 rtl/rs_rr_arbiter.sv | 72 +++++++
 tb/tb_rs_rr_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rs_rr_arbiter.sv
// rs_rr_arbiter: round-robin, packet-locking arbiter onto one registered valid/ready channel.
module rs_rr_arbiter #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 32,
    parameter int SRC_W  = $clog2(N_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_SRC-1:0]          s_valid,
    output logic [N_SRC-1:0]          s_ready,
    input  logic [N_SRC*DATA_W-1:0]   s_data,
    input  logic [N_SRC-1:0]          s_last,
    output logic                      d_valid,
    input  logic                      d_ready,
    output logic [DATA_W-1:0]         d_data,
    output logic                      d_last,
    output logic [SRC_W-1:0]          d_src
);
    typedef enum logic {IDLE, LOCK} state_t;
    state_t state;
    logic [SRC_W-1:0] ptr, lock_src, win, nxt_ptr;
    logic [N_SRC-1:0] grant;
    logic ld, acc, found;
    int j;
    // While locked only the owner may move; otherwise scan from ptr with wrap.
    always_comb begin
        grant = '0;
        win = lock_src;
        found = 1'b0;
        j = 0;
        if (state == LOCK) grant[lock_src] = s_valid[lock_src];
        else
            for (int k = 0; k < N_SRC; k++) begin
                j = int'(ptr) + k;
                if (j >= N_SRC) j = j - N_SRC;
                if (!found && s_valid[j]) begin
                    found = 1'b1;
                    win = SRC_W'(j);
                    grant[j] = 1'b1;
                end
            end
    end
    assign ld      = !d_valid || d_ready;
    assign s_ready = (ld && !rst) ? grant : '0;
    assign acc     = |s_ready;
    assign nxt_ptr = (win == SRC_W'(N_SRC - 1)) ? '0 : win + SRC_W'(1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid  <= 1'b0;
            d_data   <= '0;
            d_last   <= 1'b0;
            d_src    <= '0;
            ptr      <= '0;
            lock_src <= '0;
            state    <= IDLE;
        end else if (ld) begin
            d_valid <= acc;
            if (acc) begin
                d_data <= s_data[int'(win)*DATA_W +: DATA_W];
                d_last <= s_last[win];
                d_src  <= win;
                if (s_last[win]) begin
                    state <= IDLE;
                    ptr   <= nxt_ptr;
                end else begin
                    state    <= LOCK;
                    lock_src <= win;
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_rr_arbiter.sv
// tb_rs_rr_arbiter: directed test-plan checks plus a reference model and scoreboard run every cycle.
module tb_rs_rr_arbiter;
    localparam int N = 4;
    localparam int DW = 32;
    logic clk = 1'b0, rst = 1'b1, d_ready = 1'b1;
    logic [N-1:0] s_valid = '0, s_ready, s_last = '0;
    logic [N*DW-1:0] s_data = '0;
    logic d_valid, d_last;
    logic [DW-1:0] d_data;
    logic [1:0] d_src;
    int n_checks = 0, n_fail = 0;

    rs_rr_arbiter #(.N_SRC(N), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data),
        .d_last(d_last), .d_src(d_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        s_data[i*DW +: DW] = v;
    endtask

    // Reference model: expected beats queued on modelled accept, retired on modelled drain.
    logic [34:0] sb[$];
    logic m_dv = 1'b0, m_lock = 1'b0;
    int m_ptr = 0, m_lsrc = 0;

    always @(negedge clk) begin
        logic [N-1:0] g;
        int w, idx;
        logic ldm;
        if (rst) begin
            check("s_ready_in_reset", 64'(s_ready), 64'd0);
            sb.delete();
            m_dv = 1'b0; m_lock = 1'b0; m_ptr = 0; m_lsrc = 0;
        end else begin
            g = '0;
            w = m_lsrc;
            if (m_lock) begin
                if (s_valid[m_lsrc]) g[m_lsrc] = 1'b1;
            end else begin
                idx = m_ptr;
                repeat (N) begin
                    if (g == '0 && s_valid[idx]) begin g[idx] = 1'b1; w = idx; end
                    idx = (idx + 1) % N;
                end
            end
            ldm = !m_dv || d_ready;
            check("model_s_ready", 64'(s_ready), 64'(ldm ? g : '0));
            check("model_d_valid", 64'(d_valid), 64'(m_dv));
            if (m_dv && sb.size() != 0)
                check("model_beat", {29'd0, d_src, d_last, d_data}, 64'(sb[0]));
            if (ldm) begin
                if (m_dv && sb.size() != 0) void'(sb.pop_front());
                m_dv = (g != '0);
                if (g != '0) begin
                    sb.push_back({2'(w), s_last[w], s_data[w*DW +: DW]});
                    if (s_last[w]) begin m_lock = 1'b0; m_ptr = (w + 1) % N; end
                    else begin m_lock = 1'b1; m_lsrc = w; end
                end
            end
        end
    end

    initial begin
        // Reset state
        s_valid = 4'hF;
        #2;
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_d_valid", 64'(d_valid), 64'd0);
        check("rst_d_src", 64'(d_src), 64'd0);
        s_valid = '0;
        step(); rst = 1'b0;
        // Single beat from src2
        s_valid = 4'b0100; s_last = 4'b0100; set_data(2, 32'hA5A5_0001);
        #1 check("t1_s_ready", 64'(s_ready), 64'b0100);
        step(); s_valid = '0;
        #1;
        check("t1_d_valid", 64'(d_valid), 64'd1);
        check("t1_d_data", 64'(d_data), 64'hA5A5_0001);
        check("t1_d_src", 64'(d_src), 64'd2);
        check("t1_d_last", 64'(d_last), 64'd1);
        check("t1_ptr", 64'(dut.ptr), 64'd3);
        step();
        // Round robin from reset
        rst = 1'b1; step(); rst = 1'b0;
        s_valid = 4'hF; s_last = 4'hF;
        for (int i = 0; i < N; i++) set_data(i, 32'(i));
        for (int k = 0; k < 6; k++) begin
            step();
            check("rr_d_valid", 64'(d_valid), 64'd1);
            check("rr_d_src", 64'(d_src), 64'(k % N));
            check("rr_onehot", 64'($countones(s_ready)), 64'd1);
        end
        s_valid = '0; step();
        // Packet lock: src1 3-beat packet while src0/src3 wait
        rst = 1'b1; step(); rst = 1'b0;
        s_valid = 4'b0001; s_last = 4'hF; set_data(0, 32'h55);
        step();
        s_valid = 4'b1011; s_last = 4'b1001; set_data(1, 32'h100);
        #1 check("lk_ready0", 64'(s_ready), 64'b0010);
        step(); set_data(1, 32'h101);
        #1 check("lk_ready1", 64'(s_ready), 64'b0010);
        check("lk_src1", 64'(d_src), 64'd1);
        step(); set_data(1, 32'h102); s_last[1] = 1'b1;
        #1 check("lk_ready2", 64'(s_ready), 64'b0010);
        check("lk_src2", 64'(d_src), 64'd1);
        step(); s_valid[1] = 1'b0;
        #1 check("lk_next_src3", 64'(s_ready), 64'b1000);
        check("lk_src3", 64'(d_src), 64'd1);
        check("lk_last", 64'(d_last), 64'd1);
        step(); s_valid = '0;
        #1 check("lk_out_src3", 64'(d_src), 64'd3);
        // Locked bubble on src1 with src0 waiting
        s_valid = 4'b0010; s_last = 4'b0000; set_data(1, 32'h200);
        #1 check("bb_grant1", 64'(s_ready), 64'b0010);
        step(); s_valid = 4'b0001; s_last = 4'b0001;
        #1 check("bb_hold0", 64'(s_ready), 64'd0);
        check("bb_beat1", 64'(d_src), 64'd1);
        step();
        check("bb_bubble0", 64'(d_valid), 64'd0);
        check("bb_hold1", 64'(s_ready), 64'd0);
        step(); s_valid = 4'b0011; s_last = 4'b0011; set_data(1, 32'h201);
        #1 check("bb_bubble1", 64'(d_valid), 64'd0);
        check("bb_resume", 64'(s_ready), 64'b0010);
        step(); s_valid = 4'b0001;
        #1 check("bb_end_src", 64'(d_src), 64'd1);
        check("bb_src0_now", 64'(s_ready), 64'b0001);
        step(); s_valid = '0;
        #1 check("bb_out_src0", 64'(d_src), 64'd0);
        step();
        // Backpressure
        s_valid = 4'b0100; s_last = 4'b0100; set_data(2, 32'hBEEF);
        step(); d_ready = 1'b0; set_data(2, 32'hBEF0);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_s_ready", 64'(s_ready), 64'd0);
            check("bp_d_data", 64'(d_data), 64'hBEEF);
            check("bp_d_src", 64'(d_src), 64'd2);
            check("bp_d_valid", 64'(d_valid), 64'd1);
            step();
        end
        d_ready = 1'b1;
        #1 check("bp_release", 64'(s_ready), 64'b0100);
        step(); s_valid = '0;
        #1 check("bp_next", 64'(d_data), 64'hBEF0);
        step();
        check("bp_drain", 64'(d_valid), 64'd0);
        // Async reset while locked on src2
        s_valid = 4'b0100; s_last = 4'b0000; set_data(2, 32'hC0DE);
        step();
        #1 rst = 1'b1;
        #1;
        check("ar_d_valid", 64'(d_valid), 64'd0);
        check("ar_s_ready", 64'(s_ready), 64'd0);
        check("ar_ptr", 64'(dut.ptr), 64'd0);
        step(); rst = 1'b0; s_valid = 4'b0101; s_last = 4'b0101; set_data(0, 32'hD00D);
        #1 check("ar_src0_first", 64'(s_ready), 64'b0001);
        step(); s_valid = '0;
        #1 check("ar_out_src0", 64'(d_src), 64'd0);
        step();
        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            s_valid = 4'($urandom);
            s_last = 4'($urandom);
            for (int i = 0; i < N; i++) set_data(i, $urandom);
            d_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        s_valid = '0; d_ready = 1'b1;
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
